// File: rtl/mem_write_buffer_pkg.sv
// Shared definitions for the store write buffer: size encodings, default depth
// and the buffered-entry record with its precomputed dword tags and span mask.
package mem_write_buffer_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_WORD  = 2'd1;
  localparam logic [1:0] SZ_DWORD = 2'd2;

  localparam int DEFAULT_DEPTH = 4;

  // tag0 is the dword holding the first byte; tag1 the following dword.
  // mask[3:0] covers tag0 bytes, mask[7:4] the spill into tag1.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [29:0] tag0;
    logic [29:0] tag1;
    logic [7:0]  mask;
  } entry_t;

endpackage

// File: rtl/wbuf_overlap.sv
// Byte-span generation for a write (addr/size) and overlap test of a stored
// write span against a dword-sized read that may straddle two dwords.
module wbuf_overlap
  import mem_write_buffer_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic [29:0] i_tag0,
  input  logic [29:0] i_tag1,
  input  logic [7:0]  i_mask,
  input  logic [31:0] i_rd_addr,
  output logic [29:0] o_tag0,
  output logic [29:0] o_tag1,
  output logic [7:0]  o_mask,
  output logic        o_hit
);

  logic [3:0]  w_base;
  logic [29:0] w_rd_tag0;
  logic [29:0] w_rd_tag1;
  logic [7:0]  w_rd_mask;

  // Reserved size code 3 falls into the dword case.
  always_comb begin
    w_base = 4'hF;
    case (i_size)
      SZ_BYTE: w_base = 4'h1;
      SZ_WORD: w_base = 4'h3;
      default: w_base = 4'hF;
    endcase
  end

  assign o_mask = {4'b0000, w_base} << i_addr[1:0];
  assign o_tag0 = i_addr[31:2];
  assign o_tag1 = i_addr[31:2] + 30'd1;

  assign w_rd_mask = 8'h0F << i_rd_addr[1:0];
  assign w_rd_tag0 = i_rd_addr[31:2];
  assign w_rd_tag1 = i_rd_addr[31:2] + 30'd1;

  assign o_hit = ((i_tag0 == w_rd_tag0) && |(i_mask[3:0] & w_rd_mask[3:0])) ||
                 ((i_tag0 == w_rd_tag1) && |(i_mask[3:0] & w_rd_mask[7:4])) ||
                 ((i_tag1 == w_rd_tag0) && |(i_mask[7:4] & w_rd_mask[3:0])) ||
                 ((i_tag1 == w_rd_tag1) && |(i_mask[7:4] & w_rd_mask[7:4]));

endmodule

// File: rtl/mem_write_buffer.sv
// Store write buffer between writeback and the data cache: strict FIFO drain,
// registered full/empty, and combinational read-after-write dependency check.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_v,
  input  logic        wb_wmem,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  input  logic [1:0]  wb_size,
  output logic        wbuf_full,
  input  logic        rd_v,
  input  logic [31:0] rd_addr,
  output logic        rd_dep,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  output logic        wbuf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [PTR_W-1:0]   r_wp;
  logic [PTR_W-1:0]   r_rp;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_enq;
  logic               w_deq;
  logic               w_head_v;
  entry_t             w_head;
  entry_t             w_new;
  logic [29:0]        w_in_tag0;
  logic [29:0]        w_in_tag1;
  logic [7:0]         w_in_mask;
  logic               w_in_hit;
  logic [DEPTH-1:0]   w_ent_hit;
  logic [DEPTH-1:0][29:0] w_ent_tag0;
  logic [DEPTH-1:0][29:0] w_ent_tag1;
  logic [DEPTH-1:0][7:0]  w_ent_mask;
  logic               w_unused_gen;

  assign wbuf_full  = (r_cnt == CNT_W'(DEPTH));
  assign wbuf_empty = (r_cnt == '0);
  assign mem_req    = !wbuf_empty;

  assign w_enq = wb_v & wb_wmem & !wbuf_full;
  assign w_deq = mem_req & mem_ack;

  assign w_head_v = r_vld[r_rp];
  assign w_head   = r_mem[r_rp];
  assign mem_addr = w_head_v ? w_head.addr : '0;
  assign mem_data = w_head_v ? w_head.data : '0;
  assign mem_size = w_head_v ? w_head.size : '0;

  wbuf_overlap u_in_ovl (
    .i_addr    (wb_addr),
    .i_size    (wb_size),
    .i_tag0    (w_in_tag0),
    .i_tag1    (w_in_tag1),
    .i_mask    (w_in_mask),
    .i_rd_addr (rd_addr),
    .o_tag0    (w_in_tag0),
    .o_tag1    (w_in_tag1),
    .o_mask    (w_in_mask),
    .o_hit     (w_in_hit)
  );

  always_comb begin
    w_new      = '0;
    w_new.addr = wb_addr;
    w_new.data = wb_data;
    w_new.size = (wb_size == 2'd3) ? SZ_DWORD : wb_size;
    w_new.tag0 = w_in_tag0;
    w_new.tag1 = w_in_tag1;
    w_new.mask = w_in_mask;
  end

  // Stored entries compare their latched span; their regenerated span is unused.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    wbuf_overlap u_ovl (
      .i_addr    (r_mem[g].addr),
      .i_size    (r_mem[g].size),
      .i_tag0    (r_mem[g].tag0),
      .i_tag1    (r_mem[g].tag1),
      .i_mask    (r_mem[g].mask),
      .i_rd_addr (rd_addr),
      .o_tag0    (w_ent_tag0[g]),
      .o_tag1    (w_ent_tag1[g]),
      .o_mask    (w_ent_mask[g]),
      .o_hit     (w_ent_hit[g])
    );
  end

  assign w_unused_gen = ^{w_ent_tag0, w_ent_tag1, w_ent_mask};

  assign rd_dep = rd_v & ((|(w_ent_hit & r_vld)) | (wb_v & wb_wmem & w_in_hit));

  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_mem[r_wp] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      if (w_enq) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + PTR_W'(1);
      end
      if (w_deq) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: drain latency, full/drop, FIFO order,
// pointer wrap, dependency detection across dword boundaries, and reset flush.
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_v;
  logic        wb_wmem;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  wb_size;
  logic        wbuf_full;
  logic        rd_v;
  logic [31:0] rd_addr;
  logic        rd_dep;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic        wbuf_empty;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_write_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_v       (wb_v),
    .wb_wmem    (wb_wmem),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_size    (wb_size),
    .wbuf_full  (wbuf_full),
    .rd_v       (rd_v),
    .rd_addr    (rd_addr),
    .rd_dep     (rd_dep),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_size   (mem_size),
    .mem_ack    (mem_ack),
    .wbuf_empty (wbuf_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
    wb_v    = v;
    wb_wmem = v;
    wb_addr = a;
    wb_data = d;
    wb_size = s;
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input logic exp);
    rd_v    = 1'b1;
    rd_addr = a;
    #1;
    chk(tag, {31'd0, rd_dep}, {31'd0, exp});
    rd_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    rd_v    = 1'b0;
    rd_addr = 32'h0;
    mem_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_empty", {31'd0, wbuf_empty}, 32'd1);
    chk("rst_full",  {31'd0, wbuf_full},  32'd0);
    chk("rst_req",   {31'd0, mem_req},    32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_data",  mem_data, 32'h0);
    chk("rst_size",  {30'd0, mem_size}, 32'd0);
    probe("rst_dep", 32'h0, 1'b0);

    // single write: one-cycle latency, hold without ack
    set_wr(1'b1, 32'h1000, 32'hDEADBEEF, 2'd2);
    #1;
    chk("no_bypass_req", {31'd0, mem_req}, 32'd0);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    chk("t1_req",  {31'd0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h1000);
    chk("t1_data", mem_data, 32'hDEADBEEF);
    chk("t1_size", {30'd0, mem_size}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_hold_addr", mem_addr, 32'h1000);
      chk("t1_hold_data", mem_data, 32'hDEADBEEF);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_empty", {31'd0, wbuf_empty}, 32'd1);
    chk("t1_req0",  {31'd0, mem_req}, 32'd0);

    // fill, dropped fifth write with concurrent ack, FIFO order
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 2'd2);
      tick();
    end
    chk("t2_full", {31'd0, wbuf_full}, 32'd1);
    chk("t2_head1", mem_data, 32'd1);
    set_wr(1'b1, 32'h110, 32'd5, 2'd2);
    mem_ack = 1'b1;
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    mem_ack = 1'b0;
    chk("t2_notfull", {31'd0, wbuf_full}, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      chk("t2_order", mem_data, 32'(k));
      chk("t2_order_addr", mem_addr, 32'h100 + 32'(4 * (k - 1)));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    chk("t2_drained", {31'd0, wbuf_empty}, 32'd1);

    // dependency against pending writes straddling dwords
    set_wr(1'b1, 32'h2003, 32'hAB, 2'd0);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    probe("dep_byte_2000", 32'h2000, 1'b1);
    probe("dep_byte_2004", 32'h2004, 1'b0);
    rd_v = 1'b0;
    rd_addr = 32'h2000;
    #1;
    chk("dep_rdv0", {31'd0, rd_dep}, 32'd0);
    set_wr(1'b1, 32'h2006, 32'h12345678, 2'd2);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    probe("dep_dw_2008", 32'h2008, 1'b1);
    probe("dep_dw_2004", 32'h2004, 1'b1);
    probe("dep_dw_200C", 32'h200C, 1'b0);
    probe("dep_dw_200A", 32'h200A, 1'b0);
    probe("dep_dw_2007", 32'h2007, 1'b1);
    mem_ack = 1'b1;
    probe("dep_head_acked", 32'h2000, 1'b1);
    tick();
    mem_ack = 1'b0;
    probe("dep_head_gone", 32'h2000, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t3_empty", {31'd0, wbuf_empty}, 32'd1);

    // dependency against the incoming write only
    set_wr(1'b1, 32'h3000, 32'h0, 2'd2);
    probe("dep_in_3000", 32'h3000, 1'b1);
    wb_wmem = 1'b0;
    probe("dep_in_nowmem", 32'h3000, 1'b0);
    set_wr(1'b1, 32'h4000, 32'h0, 2'd3);
    probe("dep_in_rsvd", 32'h4003, 1'b1);
    set_wr(1'b1, 32'h5002, 32'h0, 2'd1);
    probe("dep_in_word_hi", 32'h5004, 1'b0);
    probe("dep_in_word_lo", 32'h5001, 1'b1);
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    #1;
    chk("t4_empty", {31'd0, wbuf_empty}, 32'd1);

    // streaming with ack every cycle wraps pointers without filling
    mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_wr(1'b1, 32'h6000 + 32'(4 * i), 32'h500 + 32'(i), 2'd2);
      #1;
      if (i > 0) chk("t5_order", mem_data, 32'h500 + 32'(i - 1));
      chk("t5_notfull", {31'd0, wbuf_full}, 32'd0);
      tick();
    end
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    chk("t5_last", mem_data, 32'h513);
    tick();
    mem_ack = 1'b0;
    chk("t5_empty", {31'd0, wbuf_empty}, 32'd1);

    // reset flushes held entries, beating a concurrent write and ack
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, 32'h7000 + 32'(4 * i), 32'h70 + 32'(i), 2'd2);
      tick();
    end
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    reset   = 1'b1;
    set_wr(1'b1, 32'h7100, 32'h99, 2'd2);
    mem_ack = 1'b1;
    tick();
    reset   = 1'b0;
    set_wr(1'b0, 32'h0, 32'h0, 2'd0);
    mem_ack = 1'b0;
    chk("t6_req0",  {31'd0, mem_req}, 32'd0);
    chk("t6_empty", {31'd0, wbuf_empty}, 32'd1);
    chk("t6_full",  {31'd0, wbuf_full}, 32'd0);
    chk("t6_addr",  mem_addr, 32'h0);
    chk("t6_data",  mem_data, 32'h0);
    for (int i = 0; i < 3; i++) probe("t6_dep", 32'h7000 + 32'(4 * i), 1'b0);
    probe("t6_dep_new", 32'h7100, 1'b0);
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("t6_still_empty", {31'd0, wbuf_empty}, 32'd1);
    chk("t6_still_req0", {31'd0, mem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
